// File: rtl/smi_mem_lib_write_burst_test_sink64.sv
// rtl/smi_mem_lib_write_burst_test_sink64.sv - write burst sink that checks a counting data sequence
//
// Stands in for a 64-bit write burst controller. Accepts one expected-sequence
// parameter set, one burst parameter set, then consumes the burst data and
// compares each word against init + n*incr. Reports a done status that is OK
// only when every word matched. Optional LFSR-driven stalls on the data port.
//
// Ports:
//   clk, srst                         clock, synchronous active-high reset
//   checkParams{Valid,DataInit,DataIncr} / checkParamsStop   expected sequence
//   writeParams{Valid,BurstAddr,BurstLen,BurstOpts} / writeParamsStop
//   writeData{Valid,Value} / writeDataStop                    data stream
//   writeDone{Valid,StatusOk} / writeDoneStop                 completion status
//   capBurstAddr, capBurstOpts        parameters of the last accepted burst
//   errCount, firstErrIndex           mismatch count (saturating) and first bad word
module smi_mem_lib_write_burst_test_sink64 #(
  parameter bit          STALL_ENABLE = 1'b0,
  parameter logic [15:0] LFSR_SEED    = 16'hACE1
) (
  input  logic        clk,
  input  logic        srst,
  input  logic        checkParamsValid,
  input  logic [63:0] checkParamDataInit,
  input  logic [63:0] checkParamDataIncr,
  output logic        checkParamsStop,
  input  logic        writeParamsValid,
  input  logic [63:0] writeParamBurstAddr,
  input  logic [31:0] writeParamBurstLen,
  input  logic [7:0]  writeParamBurstOpts,
  output logic        writeParamsStop,
  input  logic        writeDataValid,
  input  logic [63:0] writeDataValue,
  output logic        writeDataStop,
  output logic        writeDoneValid,
  output logic        writeDoneStatusOk,
  input  logic        writeDoneStop,
  output logic [63:0] capBurstAddr,
  output logic [7:0]  capBurstOpts,
  output logic [15:0] errCount,
  output logic [31:0] firstErrIndex
);

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_GET_PARAMS,
    ST_DATA,
    ST_DONE
  } state_t;

  state_t      state;
  logic [63:0] expected;
  logic [63:0] incr;
  logic [31:0] remaining;
  logic [31:0] word_index;
  logic [15:0] lfsr;
  logic        stall;
  logic        data_xfer;

  // Two low LFSR bits both set gives roughly one stall cycle in four.
  assign stall = STALL_ENABLE && lfsr[0] && lfsr[1];

  // Handshake controls decode straight from registered state (zero-cycle).
  assign checkParamsStop   = (state != ST_IDLE);
  assign writeParamsStop   = (state != ST_GET_PARAMS);
  assign writeDataStop     = (state != ST_DATA) || stall;
  assign writeDoneValid    = (state == ST_DONE);
  assign writeDoneStatusOk = (errCount == 16'h0000);
  assign data_xfer         = writeDataValid && !writeDataStop;

  always_ff @(posedge clk) begin
    if (srst) begin
      state         <= ST_IDLE;
      expected      <= 64'h0;
      incr          <= 64'h0;
      remaining     <= 32'h0;
      word_index    <= 32'h0;
      errCount      <= 16'h0000;
      firstErrIndex <= 32'h0;
      lfsr          <= LFSR_SEED;
    end else begin
      // Fibonacci, taps 16,14,13,11; free-running regardless of state.
      if (STALL_ENABLE)
        lfsr <= {lfsr[14:0], lfsr[15] ^ lfsr[13] ^ lfsr[12] ^ lfsr[10]};

      case (state)
        ST_IDLE: begin
          if (checkParamsValid) begin
            expected <= checkParamDataInit;
            incr     <= checkParamDataIncr;
            state    <= ST_GET_PARAMS;
          end
        end
        ST_GET_PARAMS: begin
          if (writeParamsValid) begin
            remaining     <= writeParamBurstLen;
            word_index    <= 32'h0;
            errCount      <= 16'h0000;
            firstErrIndex <= 32'h0;
            state         <= (writeParamBurstLen == 32'h0) ? ST_DONE : ST_DATA;
          end
        end
        ST_DATA: begin
          if (data_xfer) begin
            if (writeDataValue != expected) begin
              if (errCount != 16'hFFFF)
                errCount <= errCount + 16'd1;
              if (errCount == 16'h0000)
                firstErrIndex <= word_index;
            end
            expected   <= expected + incr;
            word_index <= word_index + 32'd1;
            remaining  <= remaining - 32'd1;
            if (remaining == 32'd1)
              state <= ST_DONE;
          end
        end
        ST_DONE: begin
          if (!writeDoneStop)
            state <= ST_IDLE;
        end
        default: state <= ST_IDLE;
      endcase
    end
  end

  // Capture registers carry no reset; they only follow accepted bursts.
  always_ff @(posedge clk) begin
    if (!srst && state == ST_GET_PARAMS && writeParamsValid) begin
      capBurstAddr <= writeParamBurstAddr;
      capBurstOpts <= writeParamBurstOpts;
    end
  end

endmodule

// File: tb/tb_smi_mem_lib_write_burst_test_sink64.sv
// tb/tb_smi_mem_lib_write_burst_test_sink64.sv - randomized self-checking bench for the write burst sink
module tb_smi_mem_lib_write_burst_test_sink64;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        srst;
  logic        sel;
  logic        cpv;
  logic [63:0] cinit, cincr;
  logic        wpv;
  logic [63:0] waddr;
  logic [31:0] wlen;
  logic [7:0]  wopts;
  logic        wdv;
  logic [63:0] wdata;
  logic        dstop;

  logic        cps0, wps0, wds0, dv0, ok0, cps1, wps1, wds1, dv1, ok1;
  logic [63:0] addr0, addr1;
  logic [7:0]  opts0, opts1;
  logic [15:0] err0, err1;
  logic [31:0] fei0, fei1;

  logic        cps, wps, wds, dv, ok;
  logic [63:0] caddr;
  logic [7:0]  copts;
  logic [15:0] err;
  logic [31:0] fei;

  assign cps   = sel ? cps1  : cps0;
  assign wps   = sel ? wps1  : wps0;
  assign wds   = sel ? wds1  : wds0;
  assign dv    = sel ? dv1   : dv0;
  assign ok    = sel ? ok1   : ok0;
  assign caddr = sel ? addr1 : addr0;
  assign copts = sel ? opts1 : opts0;
  assign err   = sel ? err1  : err0;
  assign fei   = sel ? fei1  : fei0;

  smi_mem_lib_write_burst_test_sink64 #(.STALL_ENABLE(1'b0)) dut0 (
    .clk(clk), .srst(srst),
    .checkParamsValid(cpv && !sel), .checkParamDataInit(cinit), .checkParamDataIncr(cincr),
    .checkParamsStop(cps0),
    .writeParamsValid(wpv && !sel), .writeParamBurstAddr(waddr), .writeParamBurstLen(wlen),
    .writeParamBurstOpts(wopts), .writeParamsStop(wps0),
    .writeDataValid(wdv && !sel), .writeDataValue(wdata), .writeDataStop(wds0),
    .writeDoneValid(dv0), .writeDoneStatusOk(ok0), .writeDoneStop(dstop || sel),
    .capBurstAddr(addr0), .capBurstOpts(opts0), .errCount(err0), .firstErrIndex(fei0)
  );

  smi_mem_lib_write_burst_test_sink64 #(.STALL_ENABLE(1'b1), .LFSR_SEED(16'hACE1)) dut1 (
    .clk(clk), .srst(srst),
    .checkParamsValid(cpv && sel), .checkParamDataInit(cinit), .checkParamDataIncr(cincr),
    .checkParamsStop(cps1),
    .writeParamsValid(wpv && sel), .writeParamBurstAddr(waddr), .writeParamBurstLen(wlen),
    .writeParamBurstOpts(wopts), .writeParamsStop(wps1),
    .writeDataValid(wdv && sel), .writeDataValue(wdata), .writeDataStop(wds1),
    .writeDoneValid(dv1), .writeDoneStatusOk(ok1), .writeDoneStop(dstop || !sel),
    .capBurstAddr(addr1), .capBurstOpts(opts1), .errCount(err1), .firstErrIndex(fei1)
  );

  int errors = 0;
  int checks = 0;
  int cyc = 0;
  int last_stalls = 0;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    if (obs !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic send_check_params(input logic [63:0] i, input logic [63:0] n);
    cinit = i;
    cincr = n;
    cpv = 1'b1;
    for (int k = 0; k < 200 && cps; k++) tick();
    if (cps) check("check_params_timeout", 1, 0);
    tick();
    cpv = 1'b0;
  endtask

  task automatic send_write_params(input logic [63:0] a, input logic [31:0] l, input logic [7:0] o);
    waddr = a;
    wlen  = l;
    wopts = o;
    wpv = 1'b1;
    for (int k = 0; k < 200 && wps; k++) tick();
    if (wps) check("write_params_timeout", 1, 0);
    tick();
    wpv = 1'b0;
  endtask

  task automatic send_word(input logic [63:0] v, inout int stalls);
    wdata = v;
    wdv = 1'b1;
    for (int k = 0; k < 200 && wds; k++) begin
      stalls++;
      tick();
    end
    if (wds) check("data_timeout", 1, 0);
    tick();
    wdv = 1'b0;
  endtask

  // Full burst; the reference recomputes every expected word as init + i*incr.
  task automatic run_burst(input string name, input logic [63:0] init, input logic [63:0] inc,
                           input logic [63:0] addr, input logic [7:0] opts,
                           input logic [63:0] data[$], input bit gaps, input int hold,
                           input bit chk_lat);
    int          t0;
    int          stalls;
    int          exp_err;
    int          exp_first;
    logic        ok_first;
    stalls = 0;
    send_check_params(init, inc);
    send_write_params(addr, 32'(data.size()), opts);
    t0 = cyc;
    if (data.size() == 0) begin
      wdv = 1'b1;
      wdata = init;
      check({name, "_len0_data_stop"}, wds, 1);
      check({name, "_len0_done_now"}, dv, 1);
      wdv = 1'b0;
    end
    for (int i = 0; i < data.size(); i++) begin
      if (gaps && $urandom_range(0, 3) == 0) tick();
      send_word(data[i], stalls);
    end
    last_stalls = stalls;
    for (int k = 0; k < 200 && !dv; k++) tick();
    if (chk_lat) check({name, "_done_lat"}, 64'(cyc - t0), 64'(data.size()));
    check({name, "_done_valid"}, dv, 1);

    exp_err = 0;
    exp_first = 0;
    for (int i = 0; i < data.size(); i++) begin
      if (data[i] !== init + inc * 64'(i)) begin
        if (exp_err == 0) exp_first = i;
        exp_err++;
      end
    end
    check({name, "_status_ok"}, ok, (exp_err == 0));
    check({name, "_err_count"}, err, 64'(exp_err));
    if (exp_err != 0) check({name, "_first_err"}, fei, 64'(exp_first));
    check({name, "_cap_addr"}, caddr, addr);
    check({name, "_cap_opts"}, copts, opts);

    ok_first = ok;
    for (int h = 0; h < hold; h++) begin
      tick();
      check({name, "_hold_valid"}, dv, 1);
      check({name, "_hold_ok"}, ok, ok_first);
    end
    dstop = 1'b0;
    tick();
    dstop = 1'b1;
    check({name, "_idle_cps"}, cps, 0);
    check({name, "_idle_done"}, dv, 0);
  endtask

  initial begin
    logic [63:0] q[$];
    logic [63:0] ri, rn, v;
    int          len;
    bit          corrupt, gaps;
    int          st;

    srst = 1'b1; sel = 1'b0; cpv = 1'b0; wpv = 1'b0; wdv = 1'b0; dstop = 1'b1;
    cinit = '0; cincr = '0; waddr = '0; wlen = '0; wopts = '0; wdata = '0;
    tick(); tick();
    srst = 1'b0;
    for (int s = 0; s < 2; s++) begin
      sel = s[0];
      #1;
      check("rst_cps", cps, 0);
      check("rst_wps", wps, 1);
      check("rst_wds", wds, 1);
      check("rst_done", dv, 0);
      check("rst_err", err, 0);
      check("rst_fei", fei, 0);
    end
    sel = 1'b0;
    tick();

    q = '{64'd0, 64'd1, 64'd2, 64'd3};
    run_burst("count4", 64'd0, 64'd1, 64'h1000, 8'h5A, q, 1'b0, 0, 1'b1);
    q = '{64'd0, 64'd1, 64'd7, 64'd3};
    run_burst("bad_word2", 64'd0, 64'd1, 64'h1000, 8'h11, q, 1'b0, 0, 1'b1);
    q = '{64'd0, 64'd1, 64'd2, 64'd3};
    run_burst("recover", 64'd0, 64'd1, 64'h2000, 8'h22, q, 1'b0, 0, 1'b1);
    q = '{64'hFFFF_FFFF_FFFF_FFFE, 64'd0, 64'd2};
    run_burst("wrap", 64'hFFFF_FFFF_FFFF_FFFE, 64'd2, 64'h3000, 8'h33, q, 1'b0, 0, 1'b1);
    q = {};
    run_burst("len0", 64'd9, 64'd1, 64'h4000, 8'h44, q, 1'b0, 0, 1'b1);

    for (int r = 0; r < 8; r++) begin
      ri = {$urandom, $urandom};
      rn = {$urandom, $urandom};
      len = $urandom_range(1, 24);
      corrupt = $urandom_range(0, 1) == 1;
      gaps = $urandom_range(0, 1) == 1;
      q = {};
      for (int i = 0; i < len; i++) begin
        v = ri + rn * 64'(i);
        if (corrupt && $urandom_range(0, 4) == 0) v = v ^ (64'd1 << $urandom_range(0, 63));
        q.push_back(v);
      end
      run_burst("rand", ri, rn, {$urandom, $urandom}, 8'($urandom), q, gaps, $urandom_range(0, 2), !gaps);
    end

    sel = 1'b1;
    #1;
    ri = {$urandom, $urandom};
    q = {};
    for (int i = 0; i < 256; i++) q.push_back(ri + 64'(i));
    run_burst("stall256", ri, 64'd1, 64'h5000, 8'h55, q, 1'b0, 5, 1'b0);
    check("stall256_saw_stalls", (last_stalls != 0), 1);

    sel = 1'b0;
    #1;
    st = 0;
    send_check_params(64'd0, 64'd1);
    send_write_params(64'h6000, 32'd8, 8'h66);
    send_word(64'd0, st);
    send_word(64'd1, st);
    wdv = 1'b1;
    wdata = 64'd2;
    srst = 1'b1;
    tick();
    srst = 1'b0;
    check("srst_cps", cps, 0);
    check("srst_wds", wds, 1);
    check("srst_wps", wps, 1);
    check("srst_done", dv, 0);
    wdv = 1'b0;
    for (int k = 0; k < 4; k++) begin
      tick();
      check("srst_no_done", dv, 0);
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
